// File: rtl/fp_spi_pkg.sv
// Shared types and command constants for the front-panel SPI master.
package fp_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT1,
    ST_GAP,
    ST_SHIFT2,
    ST_RECOVER
  } state_e;

  localparam logic [7:0] WRITE_LED_PORT = 8'h01;
  localparam logic [7:0] WRITE_PWM_PORT = 8'h04;
  localparam logic [7:0] READ_CHIP_ID   = 8'h06;
  localparam logic [7:0] CHIP_ID        = 8'h71;

endpackage

// File: rtl/fp_spi_clkgen.sv
// Half-period tick generator: a down-counter that fires on terminal count
// every CLKDIV enabled cycles and is reloaded while the phase is not running.
module fp_spi_clkgen
  import fp_spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic reload,
  output logic tick
);

  localparam logic [7:0] RELOAD_VAL = 8'(CLKDIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = RELOAD_VAL;
    end else if (en) begin
      cnt_d = (cnt_q == 8'd0) ? RELOAD_VAL : cnt_q - 8'd1;
    end
  end

  assign tick = en && !reload && (cnt_q == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fp_spi_master.sv
// Front-panel SPI master (mode 0, LSB first): one START produces a command
// byte, an idle gap and a data byte; the data-phase MISO byte is returned.
//   state      | meaning
//   ST_IDLE    | waiting for START, SS high
//   ST_SETUP   | SS low, MOSI = CMD[0], SCLK low for one half-period
//   ST_SHIFT1  | 8 command bits
//   ST_GAP     | GAP_CLKS idle cycles, SS low, SCLK low
//   ST_SHIFT2  | 8 data bits, MISO captured
//   ST_RECOVER | SS high for one half-period, then DONE
module fp_spi_master
  import fp_spi_pkg::*;
#(
  parameter int CLKDIV   = 2,
  parameter int GAP_CLKS = 4
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       START,
  input  logic [7:0] CMD,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RDATA,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);

  localparam logic [7:0] GAP_M1 = 8'(GAP_CLKS - 1);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d, wdata_q, wdata_d;
  logic [7:0] rx_q, rx_d, rdata_q, rdata_d;
  logic [7:0] gap_q, gap_d;
  logic [2:0] bit_q, bit_d;
  logic       byte_q, byte_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic       sclk_q, sclk_d, mosi_q, mosi_d, ss_q, ss_d;
  logic       tick, cg_reload;
  logic [7:0] tx_byte;

  assign cg_reload = (state_q == ST_IDLE) || (state_q == ST_GAP);

  fp_spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk    (CLK),
    .rst_n  (NRST),
    .en     (!cg_reload),
    .reload (cg_reload),
    .tick   (tick)
  );

  assign tx_byte = byte_q ? wdata_q : cmd_q;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_d    = ss_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          cmd_d   = CMD;
          wdata_d = WDATA;
          busy_d  = 1'b1;
          ss_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = CMD[0];
          bit_d   = 3'd0;
          byte_d  = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT1;
        end
      end
      ST_SHIFT1, ST_SHIFT2: begin
        if (tick) begin
          if (sclk_q) begin
            // falling edge: capture MISO and present the next bit
            sclk_d = 1'b0;
            if (byte_q) rx_d = {MISO, rx_q[7:1]};
            if (bit_q != 3'd7) mosi_d = tx_byte[bit_q + 3'd1];
          end else if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            sclk_d = 1'b1;
          end else begin
            bit_d = 3'd0;
            if (!byte_q) begin
              byte_d = 1'b1;
              mosi_d = wdata_q[0];
              if (GAP_CLKS == 0) begin
                sclk_d  = 1'b1;
                state_d = ST_SHIFT2;
              end else begin
                gap_d   = GAP_M1;
                state_d = ST_GAP;
              end
            end else begin
              ss_d    = 1'b1;
              state_d = ST_RECOVER;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT2;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rdata_d = rx_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= ST_IDLE;
      cmd_q   <= 8'd0;
      wdata_q <= 8'd0;
      rx_q    <= 8'd0;
      rdata_q <= 8'd0;
      gap_q   <= 8'd0;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign RDATA = rdata_q;
  assign SCLK  = sclk_q;
  assign MOSI  = mosi_q;
  assign SS    = ss_q;

endmodule

// File: tb/tb_fp_spi_master.sv
// Bench for fp_spi_master: default instance plus a CLKDIV=1/GAP_CLKS=0 instance,
// each talking to a slave model that returns a chosen byte in the data phase.
module tb_fp_spi_master;
  import fp_spi_pkg::*;

  localparam int C_DIV [2] = '{2, 1};
  localparam int C_GAP [2] = '{4, 0};

  logic       clk = 1'b0;
  logic       nrst;
  logic       start [2];
  logic [7:0] cmd [2];
  logic [7:0] wdata [2];
  logic       busy [2];
  logic       done [2];
  logic [7:0] rdata [2];
  logic       sclk [2];
  logic       mosi [2];
  logic       miso [2] = '{1'b0, 1'b0};
  logic       ss [2];

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic       ss_prev [2]   = '{1'b1, 1'b1};
  logic       sclk_prev [2] = '{1'b0, 1'b0};
  int         ss_cnt [2]    = '{0, 0};
  int         ss_len [2]    = '{0, 0};
  int         rise_cnt [2]  = '{0, 0};
  logic [15:0] mosi_cap [2] = '{16'h0, 16'h0};
  int         bad_sclk [2]  = '{0, 0};
  int         done_cnt [2]  = '{0, 0};
  logic [7:0] garb [2]      = '{8'h00, 8'h00};
  logic [7:0] resp [2]      = '{8'h00, 8'h00};

  fp_spi_master dut (
    .CLK(clk), .NRST(nrst), .START(start[0]), .CMD(cmd[0]), .WDATA(wdata[0]),
    .BUSY(busy[0]), .DONE(done[0]), .RDATA(rdata[0]), .SCLK(sclk[0]),
    .MOSI(mosi[0]), .MISO(miso[0]), .SS(ss[0])
  );

  fp_spi_master #(.CLKDIV(1), .GAP_CLKS(0)) dut_fast (
    .CLK(clk), .NRST(nrst), .START(start[1]), .CMD(cmd[1]), .WDATA(wdata[1]),
    .BUSY(busy[1]), .DONE(done[1]), .RDATA(rdata[1]), .SCLK(sclk[1]),
    .MOSI(mosi[1]), .MISO(miso[1]), .SS(ss[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus observer and slave: slave shifts garb[] during byte 1 and resp[] during byte 2.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!ss[d] && ss_prev[d]) begin
        ss_cnt[d] = 0;
        rise_cnt[d] = 0;
        mosi_cap[d] = 16'h0;
      end
      if (!ss[d]) ss_cnt[d]++;
      if (ss[d] && !ss_prev[d]) ss_len[d] = ss_cnt[d];
      if (sclk[d] && !sclk_prev[d]) begin
        if (rise_cnt[d] < 16) mosi_cap[d][rise_cnt[d][3:0]] = mosi[d];
        miso[d] = (rise_cnt[d] < 8) ? garb[d][rise_cnt[d][2:0]] : resp[d][rise_cnt[d][2:0]];
        rise_cnt[d]++;
      end
      if (sclk[d] && ss[d]) bad_sclk[d]++;
      if (done[d]) done_cnt[d]++;
      ss_prev[d] = ss[d];
      sclk_prev[d] = sclk[d];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input int d, input logic [7:0] c, input logic [7:0] w, output int t0);
    start[d] = 1'b1;
    cmd[d] = c;
    wdata[d] = w;
    t0 = cyc;
    step();
    start[d] = 1'b0;
    cmd[d] = 8'($urandom);
    wdata[d] = 8'($urandom);
  endtask

  task automatic wait_done(input int d, input string tag);
    int n = 0;
    while (done[d] !== 1'b1 && n < 1200) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done[d]}, 32'd1);
  endtask

  task automatic finish_txn(input int d, input int t0, input logic [7:0] c, input logic [7:0] w,
                            input logic [7:0] r, input string tag);
    wait_done(d, tag);
    chk({tag, "_done_time"}, cyc, t0 + 1 + 34 * C_DIV[d] + C_GAP[d]);
    chk({tag, "_busy_at_done"}, {31'd0, busy[d]}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, rdata[d]}, {24'd0, r});
    chk({tag, "_sclk_rises"}, rise_cnt[d], 16);
    chk({tag, "_mosi_bits"}, {16'd0, mosi_cap[d]}, {16'd0, w, c});
    chk({tag, "_ss_low_len"}, ss_len[d], 33 * C_DIV[d] + C_GAP[d]);
  endtask

  task automatic run_txn(input int d, input logic [7:0] c, input logic [7:0] w,
                         input logic [7:0] g, input logic [7:0] r, input string tag);
    int t0;
    garb[d] = g;
    resp[d] = r;
    launch(d, c, w, t0);
    chk({tag, "_ss_fall"}, {31'd0, ss[d]}, 32'd0);
    chk({tag, "_busy_rise"}, {31'd0, busy[d]}, 32'd1);
    finish_txn(d, t0, c, w, r, tag);
  endtask

  initial begin
    int t0, t1, dc;
    nrst = 1'b0;
    start = '{1'b0, 1'b0};
    cmd = '{8'h00, 8'h00};
    wdata = '{8'h00, 8'h00};
    repeat (3) step();
    chk("rst_ss", {31'd0, ss[0]}, 32'd1);
    chk("rst_sclk", {31'd0, sclk[0]}, 32'd0);
    chk("rst_mosi", {31'd0, mosi[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_done", {31'd0, done[0]}, 32'd0);
    chk("rst_rdata", {24'd0, rdata[0]}, 32'd0);
    chk("rst_fast_ss", {31'd0, ss[1]}, 32'd1);
    nrst = 1'b1;
    repeat (2) step();

    run_txn(0, WRITE_LED_PORT, 8'h0A, 8'($urandom), 8'($urandom), "led");

    run_txn(0, READ_CHIP_ID, 8'($urandom), 8'($urandom), CHIP_ID, "rdid");
    repeat (5) step();
    chk("rdid_hold", {24'd0, rdata[0]}, {24'd0, CHIP_ID});

    // START while busy is ignored, then a back-to-back START in the DONE cycle
    garb[0] = 8'h3C;
    resp[0] = 8'hA5;
    dc = done_cnt[0];
    launch(0, 8'h96, 8'h69, t0);
    repeat (9) step();
    start[0] = 1'b1;
    cmd[0] = 8'h55;
    wdata[0] = 8'hAA;
    step();
    start[0] = 1'b0;
    finish_txn(0, t0, 8'h96, 8'h69, 8'hA5, "ign");
    resp[0] = 8'h5A;
    launch(0, 8'hC3, 8'h0F, t1);
    chk("b2b_ss_fall", {31'd0, ss[0]}, 32'd0);
    chk("b2b_launch_time", cyc, t0 + 74);
    chk("ign_single_done", done_cnt[0] - dc, 1);
    finish_txn(0, t1, 8'hC3, 8'h0F, 8'h5A, "b2b");

    run_txn(0, WRITE_PWM_PORT, 8'hFF, 8'hFF, 8'hFF, "pwm");

    // reset in the middle of the command byte
    garb[0] = 8'h00;
    resp[0] = 8'h00;
    dc = done_cnt[0];
    launch(0, 8'hFF, 8'hFF, t0);
    while (cyc < t0 + 20) step();
    nrst = 1'b0;
    #1;
    chk("mid_rst_ss", {31'd0, ss[0]}, 32'd1);
    chk("mid_rst_sclk", {31'd0, sclk[0]}, 32'd0);
    chk("mid_rst_mosi", {31'd0, mosi[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("mid_rst_rdata", {24'd0, rdata[0]}, 32'd0);
    repeat (3) step();
    nrst = 1'b1;
    repeat (80) step();
    chk("mid_rst_no_done", done_cnt[0] - dc, 0);
    run_txn(0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "post_rst");

    run_txn(1, 8'h5C, 8'hE1, 8'($urandom), 8'h2B, "fast");
    run_txn(1, READ_CHIP_ID, 8'h00, 8'hFF, CHIP_ID, "fast_rdid");

    for (int i = 0; i < 6; i++) begin
      run_txn(i % 2, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), "rand");
    end

    chk("no_sclk_ss_high", bad_sclk[0], 0);
    chk("fast_no_sclk_ss_high", bad_sclk[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_spi_master.md
# fp_spi_master

Host-side SPI master that drives the front-panel device over SCLK/MOSI/MISO/SS. It converts a single START request into one complete two-byte front-panel transaction: a command byte, an inter-byte gap, then a data byte. It runs from the system clock and returns the byte captured on MISO during the data phase. It sits between the host bus logic and the front-panel connector, as the initiator for the front-panel SPI slave.

## Interface
Parameters:
- CLKDIV, 2: SCLK half-period in CLK cycles; legal range 1..255.
- GAP_CLKS, 4: idle CLK cycles between the command byte and the data byte; SCLK is low and SS is low during the gap; legal range 0..255.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- NRST  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle request; sampled only while BUSY=0.
- CMD  in  8  command byte; captured on the accepted START.
- WDATA  in  8  data byte; captured on the accepted START.
- BUSY  out  1  high from the cycle after START through the cycle before DONE.
- DONE  out  1  one-cycle pulse at the end of the transaction.
- RDATA  out  8  byte captured in the data phase; valid from DONE and held until the next DONE.
- SCLK  out  1  serial clock; idle level is low (mode 0).
- MOSI  out  1  serial data out, LSB first.
- MISO  in  1  serial data in, LSB first.
- SS  out  1  slave select, active low.

## Operation
- Reset values: SS=1, SCLK=0, MOSI=0, BUSY=0, DONE=0, RDATA=0x00. All internal counters are zero and the state is IDLE.
- States: IDLE -> SETUP -> SHIFT1 -> GAP -> SHIFT2 -> RECOVER -> IDLE.
- IDLE: on START=1, latch CMD and WDATA, move to SETUP, and set BUSY=1.
- SETUP: SS=0, SCLK=0, MOSI=CMD[0]. Lasts CLKDIV cycles.
- SHIFT1 and SHIFT2 each send 8 bits. For each bit, SCLK is high for CLKDIV cycles, then low for CLKDIV cycles.
- On each falling SCLK edge, MISO is sampled into a shift register (LSB first) and MOSI advances to the next bit.
- The slave samples MOSI on the rising SCLK edge and updates MISO on that same rising edge.
- After the 8th low phase of SHIFT1, move to GAP with MOSI=WDATA[0]. When GAP_CLKS=0, go directly to SHIFT2.
- MISO samples taken in SHIFT1 are discarded. Samples taken in SHIFT2 form RDATA.
- After the 8th low phase of SHIFT2, set SS=1 and enter RECOVER for CLKDIV cycles. This guarantees a minimum SS-high time.
- At the end of RECOVER: DONE=1 for one cycle, RDATA is updated, BUSY=0, return to IDLE.
- START while BUSY=1 is ignored. It is not queued.
- SCLK never toggles while SS=1. MOSI holds its last value after the final bit.
- Asserting NRST mid-transaction immediately forces the reset values. No DONE is produced and RDATA returns to 0x00.
- Counters: a half-period counter of 8 bits, a bit index of 0..7, a byte flag, and a gap counter of 8 bits. No counter wraps; each is reloaded on every state entry.

## Timing
- START accepted in cycle t0. SS falls and BUSY rises at t0+1.
- The first rising SCLK edge is at t0+1+CLKDIV.
- SS is low for 33*CLKDIV+GAP_CLKS cycles.
- DONE occurs at t0+1+34*CLKDIV+GAP_CLKS. With defaults this is t0+73.
- The earliest following START is accepted in the DONE cycle. BUSY=0 there, so back-to-back transactions are allowed.
- SCLK frequency is f_CLK/(2*CLKDIV). With CLKDIV=1, SCLK toggles every cycle.

## Structure
- Shared package fp_spi_pkg holds the state enumeration and the command constants: WRITE_LED_PORT=0x01, WRITE_PWM_PORT=0x04, READ_CHIP_ID=0x06, CHIP_ID=0x71.
- Sub-module fp_spi_clkgen is the half-period tick counter. It has an enable and a reload, and emits a tick every CLKDIV cycles.
- The FSM, shift registers and bit counter live in fp_spi_master.

## Test plan
- Write LED: CMD=0x01, WDATA=0x0A -> MOSI at rising edges is 1,0,0,0,0,0,0,0 then 0,1,0,1,0,0,0,0; 16 SCLK rising edges; DONE at t0+73.
- Read ID: CMD=0x06 against a slave model returning 0x71 in byte 2 -> RDATA=0x71 at DONE; RDATA holds after DONE.
- Timing corners: CLKDIV=1, GAP_CLKS=0 -> SS low for exactly 33 cycles; DONE at t0+35; no SCLK edge while SS=1.
- START during BUSY: a second START at t0+10 -> ignored; exactly one DONE, at t0+73; then back-to-back START in the DONE cycle -> SS falls at t0+74.
- Reset mid-byte: NRST low at t0+20 -> SS=1, SCLK=0, MOSI=0, BUSY=0, RDATA=0x00 in the same cycle; no DONE; the next transaction is normal.
- Write PWM: CMD=0x04, WDATA=0xFF, with MISO held at 1 -> RDATA=0xFF, and the MOSI data byte is all ones.
